// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq: sequential AES SubBytes engine for one 128-bit state.
// A state is accepted on an in_valid/in_ready handshake.
// LANES S-boxes then substitute LANES bytes per cycle, in ascending byte order.
// The result is held on out_state/out_valid until the consumer takes it.
// Optional feature macro: AES_INV_SBOX_EN. When it is defined, the engine adds an
// inv_mode port and an inverse S-box in every lane.
module aes_sub_bytes_seq #(
   parameter int unsigned STATE_BYTES = 16,
   parameter int unsigned LANES       = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [8*STATE_BYTES-1:0] in_state,
`ifdef AES_INV_SBOX_EN
   input  logic                     inv_mode,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [8*STATE_BYTES-1:0] out_state,
   output logic                     busy
);

   localparam int unsigned SW = 8 * STATE_BYTES;
   localparam int unsigned GW = 8 * LANES;
   localparam int unsigned N  = STATE_BYTES / LANES;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned IW = $clog2(SW);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Shift-and-add GF(2^8) multiplier.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254 = a^2*a^4*...*a^128. Zero maps to zero.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   // Forward affine map: s_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ 0x63.
   function automatic logic [7:0] affine_fwd(input logic [7:0] b);
      return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]} ^ {b[5:0], b[7:6]}
               ^ {b[6:0], b[7]} ^ 8'h63;
   endfunction

   // Forward S-box.
   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      return affine_fwd(gf_inv(b));
   endfunction

`ifdef AES_INV_SBOX_EN
   // Inverse affine map: b_i = s_(i+2) ^ s_(i+5) ^ s_(i+7) ^ 0x05.
   function automatic logic [7:0] affine_inv(input logic [7:0] s);
      return {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ 8'h05;
   endfunction

   // Inverse S-box.
   function automatic logic [7:0] sbox_inv(input logic [7:0] s);
      return gf_inv(affine_inv(s));
   endfunction
`endif

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   work_q, work_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;
`ifdef AES_INV_SBOX_EN
   logic            inv_q, inv_d;
`endif

   logic [IW-1:0]   grp_base;
   logic [GW-1:0]   grp_in;
   logic [GW-1:0]   grp_out;

   // Bit offset of the byte group handled in the current RUN cycle.
   assign grp_base = IW'(32'(cnt_q) * GW);
   assign grp_in   = work_q[grp_base +: GW];

   // One S-box per lane over the current byte group.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef AES_INV_SBOX_EN
      assign grp_out[8*l +: 8] = inv_q ? sbox_inv(grp_in[8*l +: 8])
                                       : sbox_fwd(grp_in[8*l +: 8]);
`else
      assign grp_out[8*l +: 8] = sbox_fwd(grp_in[8*l +: 8]);
`endif
   end

   // State register, counter, work register and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef AES_INV_SBOX_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef AES_INV_SBOX_EN
         inv_q       <= inv_d;
`endif
      end
   end

   // Next-state logic; the handshake flags are decoded from the next state so they track state_q.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
`ifdef AES_INV_SBOX_EN
      inv_d       = inv_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_RUN;
               cnt_d   = '0;
               work_d  = in_state;
`ifdef AES_INV_SBOX_EN
               inv_d   = inv_mode;
`endif
            end
         end
         S_RUN: begin
            work_d[grp_base +: GW] = grp_out;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_state = work_q;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq.
// It runs three engines side by side with LANES=1, 4 and 16. A driver per engine pushes expected
// states into a queue. A monitor per engine pops and compares on every output handshake.
// Expected S-box values come from a table built by brute-force GF(2^8) inversion.
`timescale 1ns/1ps
module tb_aes_sub_bytes_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit done [3];

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   // Carry-less polynomial product reduced modulo 0x11b.
   function automatic logic [7:0] gmul_ref(input int a, input int b);
      int p;
      p = 0;
      for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
      for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ (32'h11b << (i - 8));
      return 8'(p);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
      logic [15:0] d;
      d = {x, x} >> (8 - k);
      return d[7:0];
   endfunction

   function automatic logic [127:0] rev(input logic [127:0] x);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
      return r;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input bit im);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = im ? inv_tab[s[8*i +: 8]] : fwd_tab[s[8*i +: 8]];
      return r;
   endfunction

   task automatic chk(input int g, input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL cfg%0d %s: got %h expected %h", g, nm, act, exp);
      end
   endtask

   // Reference S-box tables: inverse found by search, then the affine map with rotations.
   initial begin
      logic [7:0] y;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         y = 8'h00;
         for (int c = 1; c < 256; c++) if (gmul_ref(x, c) == 8'h01) y = 8'(c);
         s = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
         fwd_tab[x] = s;
         inv_tab[s] = 8'(x);
      end
   end

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int unsigned LN = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
      localparam int N = int'(16 / LN);

      logic         rst_n;
      logic         in_valid;
      logic         in_ready;
      logic         out_valid;
      logic         out_ready;
      logic         busy;
      logic [127:0] in_state;
      logic [127:0] out_state;
`ifdef AES_INV_SBOX_EN
      logic         inv_mode;
`endif

      logic [127:0] exp_q [$];
      int           acc_q [$];
      int           last_hs = -1;

      aes_sub_bytes_seq #(.STATE_BYTES(16), .LANES(LN)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_state  (in_state),
`ifdef AES_INV_SBOX_EN
         .inv_mode  (inv_mode),
`endif
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_state (out_state),
         .busy      (busy)
      );

      // Present one state with in_valid held high. Scramble the inputs while the engine is busy.
      task automatic send(input logic [127:0] v, input bit im, input logic [127:0] e);
         bit waited;
         waited   = 1'b0;
         in_valid = 1'b1;
         forever begin
            if (in_ready) begin
               in_state = v;
`ifdef AES_INV_SBOX_EN
               inv_mode = im;
`endif
               break;
            end
            waited   = 1'b1;
            in_state = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_SBOX_EN
            inv_mode = ~inv_mode;
`endif
            @(negedge clk);
         end
         if (waited) chk(g, "reaccept_cycle", 128'(cyc), 128'(last_hs));
         exp_q.push_back(e);
         acc_q.push_back(cyc + 1);
         @(negedge clk);
         chk(g, "in_ready_after_accept", 128'(in_ready), 128'(0));
         chk(g, "busy_after_accept", 128'(busy), 128'(1));
      endtask

      // Driver
      initial begin
         logic [127:0] v;
         bit           im;
         rst_n    = 1'b0;
         in_valid = 1'b0;
         in_state = '0;
`ifdef AES_INV_SBOX_EN
         inv_mode = 1'b0;
`endif
         repeat (2) @(negedge clk);
         chk(g, "reset_in_ready", 128'(in_ready), 128'(1));
         chk(g, "reset_out_valid", 128'(out_valid), 128'(0));
         chk(g, "reset_busy", 128'(busy), 128'(0));
         chk(g, "reset_out_state", out_state, 128'(0));
         rst_n = 1'b1;
         @(negedge clk);

         send(128'h0, 1'b0, {16{8'h63}});
         send(rev(128'h193de3bea0f4e22b9ac68d2ae9f84808), 1'b0,
              rev(128'hd42711aee0bf98f1b8b45de51e415230));
         send({16{8'h53}}, 1'b0, {16{8'hed}});
`ifdef AES_INV_SBOX_EN
         send({16{8'h63}}, 1'b1, 128'h0);
         send({16{8'hed}}, 1'b1, {16{8'h53}});
         send(rev(128'hd42711aee0bf98f1b8b45de51e415230), 1'b1,
              rev(128'h193de3bea0f4e22b9ac68d2ae9f84808));
`endif
         for (int i = 0; i < 24; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_SBOX_EN
            im = 1'($urandom_range(0, 1));
`else
            im = 1'b0;
`endif
            send(v, im, model(v, im));
            if ($urandom_range(0, 2) == 0) begin
               in_valid = 1'b0;
               repeat ($urandom_range(1, 4)) @(negedge clk);
            end
         end

         // Abort a state mid-RUN with an asynchronous reset.
         in_valid = 1'b0;
         while (exp_q.size() != 0) @(negedge clk);
         send({16{8'h11}}, 1'b0, {16{8'h82}});
         in_valid = 1'b0;
         repeat ((N > 7) ? 7 : N - 1) @(posedge clk);
         #1 rst_n = 1'b0;
         #1;
         chk(g, "abort_out_valid", 128'(out_valid), 128'(0));
         chk(g, "abort_in_ready", 128'(in_ready), 128'(1));
         chk(g, "abort_busy", 128'(busy), 128'(0));
         chk(g, "abort_out_state", out_state, 128'(0));
         void'(exp_q.pop_back());
         void'(acc_q.pop_back());
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         send({16{8'h01}}, 1'b0, {16{8'h7c}});
         send({16{8'hff}}, 1'b0, {16{8'h16}});
         in_valid = 1'b0;
         while (exp_q.size() != 0) @(negedge clk);
         done[g] = 1'b1;
      end

      // Monitor: drives out_ready with random back-pressure and checks every output handshake.
      initial begin
         bit           pv;
         bit           pr;
         int           hold;
         int           a;
         logic [127:0] ps;
         pv = 1'b0;
         pr = 1'b0;
         hold = 0;
         ps = '0;
         out_ready = 1'b1;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               pv = 1'b0;
               pr = 1'b0;
               hold = 0;
               continue;
            end
            if (pv && !pr) begin
               chk(g, "held_out_valid", 128'(out_valid), 128'(1));
               chk(g, "held_out_state", out_state, ps);
            end
            if (out_valid && !pv) begin
               if (acc_q.size() == 0) chk(g, "spurious_out_valid", 128'(1), 128'(0));
               else begin
                  a = acc_q.pop_front();
                  chk(g, "latency", 128'(cyc), 128'(a + N));
               end
               if ($urandom_range(0, 3) == 0) hold = 5;
            end
            chk(g, "busy_vs_in_ready", 128'(busy), 128'(!in_ready));
            if (out_valid) chk(g, "in_ready_in_done", 128'(in_ready), 128'(0));
            if (hold > 0) begin
               out_ready = 1'b0;
               hold--;
            end else begin
               out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) chk(g, "spurious_output", 128'(1), 128'(0));
               else chk(g, "out_state", out_state, exp_q.pop_front());
               last_hs = cyc + 1;
            end
            pv = out_valid;
            pr = out_ready;
            ps = out_state;
         end
      end
   end

   initial begin
      wait (done[0] && done[1] && done[2]);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog: got cycle %0d expected completion before it", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
